// File: rtl/tile_buffer_bank.sv
// Multi-bank tile buffer between the load unit and the compute array.
// Each bank runs its own fill/drain state machine. A write into one bank and a read from another can complete in the same cycle.
module tile_buffer_bank #(
    parameter int BUFFER_WIDTH = 1024,
    parameter int BUFFER_COUNT = 4,
    parameter int TILE_WIDTH   = 256,
    parameter int DATA_WIDTH   = 8,
    localparam int MAX_TILES   = BUFFER_WIDTH / TILE_WIDTH,
    localparam int TILE_ELEMS  = TILE_WIDTH / DATA_WIDTH,
    localparam int BID_W       = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
    localparam int LEN_W       = $clog2(MAX_TILES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    input  logic [BID_W-1:0]        wr_buffer,
    input  logic [TILE_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    rd_req,
    input  logic [BID_W-1:0]        rd_buffer,
    input  logic                    rd_keep,
    output logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data [TILE_ELEMS],
    output logic                    rd_valid,
    input  logic                    cfg_valid,
    input  logic [BID_W-1:0]        cfg_buffer,
    input  logic [LEN_W-1:0]        cfg_tiles,
    input  logic                    clr_valid,
    input  logic [BID_W-1:0]        clr_buffer,
    output logic                    writing_done,
    output logic [BID_W-1:0]        wr_done_id,
    output logic                    reading_done,
    output logic [BID_W-1:0]        rd_done_id,
    output logic                    cfg_err,
    output logic [BUFFER_COUNT-1:0] buf_full
);

    localparam int TIDX_W = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_e;

    bank_state_e             state_q [BUFFER_COUNT];
    logic [TIDX_W-1:0]       w_ptr_q [BUFFER_COUNT];
    logic [TIDX_W-1:0]       r_ptr_q [BUFFER_COUNT];
    logic [LEN_W-1:0]        len_q   [BUFFER_COUNT];
    logic [TILE_WIDTH-1:0]   mem_q   [BUFFER_COUNT][MAX_TILES];

    logic [DATA_WIDTH-1:0]   rd_data_q [TILE_ELEMS];
    logic                    rd_valid_q;
    logic                    writing_done_q;
    logic [BID_W-1:0]        wr_done_id_q;
    logic                    reading_done_q;
    logic [BID_W-1:0]        rd_done_id_q;
    logic                    cfg_err_q;

    logic                    wr_ready_s;
    logic                    rd_ready_s;
    logic                    wr_fire_s;
    logic                    rd_fire_s;
    logic                    wr_last_s;
    logic                    rd_last_s;
    logic                    cfg_ok_s;
    logic [LEN_W-1:0]        cfg_len_s;
    logic [TILE_WIDTH-1:0]   rd_tile_s;
    logic [BUFFER_COUNT-1:0] buf_full_s;

    function automatic logic bank_ok(input logic [BID_W-1:0] b);
        return 32'(b) < 32'(BUFFER_COUNT);
    endfunction

    // Handshake decode; a same-cycle clear of the addressed bank blocks access.
    always_comb begin
        wr_ready_s = 1'b0;
        rd_ready_s = 1'b0;
        cfg_ok_s   = 1'b0;
        wr_last_s  = 1'b0;
        rd_last_s  = 1'b0;
        if (bank_ok(wr_buffer) && !(clr_valid && (clr_buffer == wr_buffer))) begin
            wr_ready_s = (state_q[wr_buffer] == ST_EMPTY) || (state_q[wr_buffer] == ST_FILLING);
            wr_last_s  = LEN_W'(w_ptr_q[wr_buffer]) == (len_q[wr_buffer] - LEN_W'(1));
        end else begin
            wr_ready_s = 1'b0;
        end
        if (bank_ok(rd_buffer) && !(clr_valid && (clr_buffer == rd_buffer))) begin
            rd_ready_s = (state_q[rd_buffer] == ST_FULL) || (state_q[rd_buffer] == ST_DRAINING);
            rd_last_s  = LEN_W'(r_ptr_q[rd_buffer]) == (len_q[rd_buffer] - LEN_W'(1));
        end else begin
            rd_ready_s = 1'b0;
        end
        if (cfg_valid && bank_ok(cfg_buffer) && !(clr_valid && (clr_buffer == cfg_buffer))) begin
            cfg_ok_s = state_q[cfg_buffer] == ST_EMPTY;
        end else begin
            cfg_ok_s = 1'b0;
        end
    end

    assign wr_fire_s = wr_valid && wr_ready_s;
    assign rd_fire_s = rd_req && rd_ready_s;
    assign cfg_len_s = ((cfg_tiles == {LEN_W{1'b0}}) || (cfg_tiles > LEN_W'(MAX_TILES)))
                       ? LEN_W'(MAX_TILES) : cfg_tiles;

    // Source tile for the read port and FULL/DRAINING status per bank.
    always_comb begin
        rd_tile_s  = {TILE_WIDTH{1'b0}};
        buf_full_s = {BUFFER_COUNT{1'b0}};
        if (bank_ok(rd_buffer)) begin
            rd_tile_s = mem_q[rd_buffer][r_ptr_q[rd_buffer]];
        end else begin
            rd_tile_s = {TILE_WIDTH{1'b0}};
        end
        for (int b = 0; b < BUFFER_COUNT; b++) begin
            buf_full_s[b] = (state_q[b] == ST_FULL) || (state_q[b] == ST_DRAINING);
        end
    end

    // Tile storage is deliberately not reset; reads are gated by bank state.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_buffer][w_ptr_q[wr_buffer]] <= wr_data;
        end
    end

    // Per-bank fill/drain state machines, pointers and programmed length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < BUFFER_COUNT; b++) begin
                state_q[b] <= ST_EMPTY;
                w_ptr_q[b] <= {TIDX_W{1'b0}};
                r_ptr_q[b] <= {TIDX_W{1'b0}};
                len_q[b]   <= LEN_W'(MAX_TILES);
            end
        end else begin
            for (int b = 0; b < BUFFER_COUNT; b++) begin
                if (clr_valid && (clr_buffer == BID_W'(b))) begin
                    state_q[b] <= ST_EMPTY;
                    w_ptr_q[b] <= {TIDX_W{1'b0}};
                    r_ptr_q[b] <= {TIDX_W{1'b0}};
                end else if (wr_fire_s && (wr_buffer == BID_W'(b))) begin
                    if (wr_last_s) begin
                        w_ptr_q[b] <= {TIDX_W{1'b0}};
                        state_q[b] <= ST_FULL;
                    end else begin
                        w_ptr_q[b] <= w_ptr_q[b] + TIDX_W'(1);
                        state_q[b] <= ST_FILLING;
                    end
                end else if (rd_fire_s && (rd_buffer == BID_W'(b))) begin
                    if (rd_last_s) begin
                        r_ptr_q[b] <= {TIDX_W{1'b0}};
                        state_q[b] <= rd_keep ? ST_FULL : ST_EMPTY;
                    end else begin
                        r_ptr_q[b] <= r_ptr_q[b] + TIDX_W'(1);
                        state_q[b] <= ST_DRAINING;
                    end
                end
                if (cfg_ok_s && (cfg_buffer == BID_W'(b))) begin
                    len_q[b] <= cfg_len_s;
                end
            end
        end
    end

    // Registered read data and event pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < TILE_ELEMS; e++) begin
                rd_data_q[e] <= {DATA_WIDTH{1'b0}};
            end
            rd_valid_q     <= 1'b0;
            writing_done_q <= 1'b0;
            wr_done_id_q   <= {BID_W{1'b0}};
            reading_done_q <= 1'b0;
            rd_done_id_q   <= {BID_W{1'b0}};
            cfg_err_q      <= 1'b0;
        end else begin
            if (rd_fire_s) begin
                for (int e = 0; e < TILE_ELEMS; e++) begin
                    rd_data_q[e] <= rd_tile_s[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            rd_valid_q     <= rd_fire_s;
            writing_done_q <= wr_fire_s && wr_last_s;
            reading_done_q <= rd_fire_s && rd_last_s;
            cfg_err_q      <= cfg_valid && !cfg_ok_s;
            if (wr_fire_s && wr_last_s) begin
                wr_done_id_q <= wr_buffer;
            end
            if (rd_fire_s && rd_last_s) begin
                rd_done_id_q <= rd_buffer;
            end
        end
    end

    assign wr_ready     = wr_ready_s;
    assign rd_ready     = rd_ready_s;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign writing_done = writing_done_q;
    assign wr_done_id   = wr_done_id_q;
    assign reading_done = reading_done_q;
    assign rd_done_id   = rd_done_id_q;
    assign cfg_err      = cfg_err_q;
    assign buf_full     = buf_full_s;

endmodule

// File: tb/tb_tile_buffer_bank.sv
// Directed self-checking bench for tile_buffer_bank at default parameters
// (4 banks, 4 tiles per bank, 32 byte elements per tile).
module tb_tile_buffer_bank;

    logic         clk;
    logic         reset_n;
    logic         wr_valid;
    logic [1:0]   wr_buffer;
    logic [255:0] wr_data;
    logic         wr_ready;
    logic         rd_req;
    logic [1:0]   rd_buffer;
    logic         rd_keep;
    logic         rd_ready;
    logic [7:0]   rd_data [32];
    logic         rd_valid;
    logic         cfg_valid;
    logic [1:0]   cfg_buffer;
    logic [2:0]   cfg_tiles;
    logic         clr_valid;
    logic [1:0]   clr_buffer;
    logic         writing_done;
    logic [1:0]   wr_done_id;
    logic         reading_done;
    logic [1:0]   rd_done_id;
    logic         cfg_err;
    logic [3:0]   buf_full;

    int checks;
    int failures;

    tile_buffer_bank dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_buffer(wr_buffer), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_buffer(rd_buffer), .rd_keep(rd_keep), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .cfg_valid(cfg_valid), .cfg_buffer(cfg_buffer), .cfg_tiles(cfg_tiles),
        .clr_valid(clr_valid), .clr_buffer(clr_buffer),
        .writing_done(writing_done), .wr_done_id(wr_done_id),
        .reading_done(reading_done), .rd_done_id(rd_done_id),
        .cfg_err(cfg_err), .buf_full(buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [7:0] v);
        return {32{v}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int bank, input logic [7:0] v, input logic exp_done);
        wr_valid  = 1'b1;
        wr_buffer = 2'(bank);
        wr_data   = pat(v);
        #1;
        check("wr_ready", 64'(wr_ready), 64'd1);
        cyc();
        wr_valid = 1'b0;
        check("writing_done", 64'(writing_done), 64'(exp_done));
        if (exp_done) check("wr_done_id", 64'(wr_done_id), 64'(bank));
    endtask

    task automatic do_read(input int bank, input logic keep, input logic [7:0] v, input logic exp_done);
        rd_req    = 1'b1;
        rd_buffer = 2'(bank);
        rd_keep   = keep;
        #1;
        check("rd_ready", 64'(rd_ready), 64'd1);
        cyc();
        rd_req  = 1'b0;
        rd_keep = 1'b0;
        check("rd_valid", 64'(rd_valid), 64'd1);
        check("rd_data0", 64'(rd_data[0]), 64'(v));
        check("rd_data31", 64'(rd_data[31]), 64'(v));
        check("reading_done", 64'(reading_done), 64'(exp_done));
        if (exp_done) check("rd_done_id", 64'(rd_done_id), 64'(bank));
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data0", 64'(rd_data[0]), 64'd0);
        check("rst_wr_done", 64'(writing_done), 64'd0);
        check("rst_rd_done", 64'(reading_done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_wr_done_id", 64'(wr_done_id), 64'd0);
        check("rst_rd_done_id", 64'(rd_done_id), 64'd0);
        check("rst_buf_full", 64'(buf_full), 64'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0;
        wr_valid = 1'b0; wr_buffer = 2'd0; wr_data = 256'd0;
        rd_req = 1'b0; rd_buffer = 2'd0; rd_keep = 1'b0;
        cfg_valid = 1'b0; cfg_buffer = 2'd0; cfg_tiles = 3'd0;
        clr_valid = 1'b0; clr_buffer = 2'd0;
        repeat (2) cyc();
        check_reset_outputs();
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_rd_ready", 64'(rd_ready), 64'd0);
        reset_n = 1'b1;
        cyc();

        // Basic fill and drain of bank 2
        for (int i = 0; i < 4; i++) begin
            do_write(2, 8'(17 * (i + 1)), i == 3);
            check("fill_buf_full", 64'(buf_full), (i == 3) ? 64'h4 : 64'h0);
        end
        for (int i = 0; i < 4; i++) do_read(2, 1'b0, 8'(17 * (i + 1)), i == 3);
        check("drain_buf_full", 64'(buf_full), 64'h0);
        cyc();
        check("idle_rd_valid", 64'(rd_valid), 64'd0);
        check("hold_rd_data", 64'(rd_data[0]), 64'h44);

        // Single-tile length on bank 0
        cfg_valid = 1'b1; cfg_buffer = 2'd0; cfg_tiles = 3'd1;
        cyc();
        cfg_valid = 1'b0;
        check("cfg1_err", 64'(cfg_err), 64'd0);
        do_write(0, 8'hA5, 1'b1);
        check("len1_full", 64'(buf_full), 64'h1);
        wr_valid = 1'b1; wr_buffer = 2'd0;
        #1;
        check("len1_wr_blocked", 64'(wr_ready), 64'd0);
        wr_valid = 1'b0;
        do_read(0, 1'b0, 8'hA5, 1'b1);
        check("len1_empty", 64'(buf_full), 64'h0);
        // zero length clamps back to four tiles
        cfg_valid = 1'b1; cfg_buffer = 2'd0; cfg_tiles = 3'd0;
        cyc();
        cfg_valid = 1'b0;
        check("cfg0_err", 64'(cfg_err), 64'd0);

        // Retain bank 1 across a read pass
        for (int i = 0; i < 4; i++) do_write(1, 8'(8'h51 + i), i == 3);
        for (int i = 0; i < 4; i++) do_read(1, 1'b1, 8'(8'h51 + i), i == 3);
        check("keep_full", 64'(buf_full), 64'h2);
        wr_buffer = 2'd1;
        #1;
        check("keep_wr_blocked", 64'(wr_ready), 64'd0);
        for (int i = 0; i < 4; i++) do_read(1, 1'b0, 8'(8'h51 + i), i == 3);
        check("keep_drained", 64'(buf_full), 64'h0);

        // Fill bank 0 while draining bank 3
        for (int i = 0; i < 4; i++) do_write(3, 8'(8'h31 + i), i == 3);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_buffer = 2'd0; wr_data = pat(8'(8'h01 + i));
            rd_req = 1'b1; rd_buffer = 2'd3; rd_keep = 1'b0;
            #1;
            check("cc_wr_ready", 64'(wr_ready), 64'd1);
            check("cc_rd_ready", 64'(rd_ready), 64'd1);
            cyc();
            check("cc_rd_valid", 64'(rd_valid), 64'd1);
            check("cc_rd_data", 64'(rd_data[7]), 64'(8'h31 + i));
            check("cc_wr_done", 64'(writing_done), 64'(i == 3));
            check("cc_rd_done", 64'(reading_done), 64'(i == 3));
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        check("cc_wr_id", 64'(wr_done_id), 64'd0);
        check("cc_rd_id", 64'(rd_done_id), 64'd3);
        check("cc_buf_full", 64'(buf_full), 64'h1);
        for (int i = 0; i < 4; i++) do_read(0, 1'b0, 8'(8'h01 + i), i == 3);

        // Clear bank 2 mid-fill; cfg while filling is rejected
        do_write(2, 8'h61, 1'b0);
        do_write(2, 8'h62, 1'b0);
        cfg_valid = 1'b1; cfg_buffer = 2'd2; cfg_tiles = 3'd2;
        cyc();
        cfg_valid = 1'b0;
        check("cfg_filling_err", 64'(cfg_err), 64'd1);
        clr_valid = 1'b1; clr_buffer = 2'd2;
        wr_valid = 1'b1; wr_buffer = 2'd2; wr_data = pat(8'hEE);
        cfg_valid = 1'b1; cfg_buffer = 2'd2; cfg_tiles = 3'd1;
        #1;
        check("clr_wr_blocked", 64'(wr_ready), 64'd0);
        cyc();
        clr_valid = 1'b0; wr_valid = 1'b0; cfg_valid = 1'b0;
        check("clr_cfg_err", 64'(cfg_err), 64'd1);
        check("clr_no_done", 64'(writing_done), 64'd0);
        for (int i = 0; i < 4; i++) do_write(2, 8'(8'h71 + i), i == 3);
        for (int i = 0; i < 4; i++) do_read(2, 1'b0, 8'(8'h71 + i), i == 3);

        // Reset while bank 1 is draining
        for (int i = 0; i < 4; i++) do_write(1, 8'(8'h81 + i), i == 3);
        do_read(1, 1'b0, 8'h81, 1'b0);
        do_read(1, 1'b0, 8'h82, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        cyc();
        reset_n = 1'b1;
        rd_buffer = 2'd1;
        #1;
        check("post_rst_rd_blocked", 64'(rd_ready), 64'd0);
        cyc();
        for (int i = 0; i < 4; i++) do_write(1, 8'(8'h91 + i), i == 3);
        for (int i = 0; i < 4; i++) do_read(1, 1'b0, 8'(8'h91 + i), i == 3);
        check("final_buf_full", 64'(buf_full), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
